// File: rtl/rf_pkg.sv
// Shared constants and index type for the scoreboarded register file.
package rf_pkg;

  localparam int RF_DATA_W   = 9;
  localparam int RF_NUM_REGS = 4;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] rf_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register/busy mux, with write-through forwarding
// when RF_BYPASS_EN is defined.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
  input  logic [NUM_REGS-1:0]             busy_i,
  input  logic [ADDR_W-1:0]               addr_i,
`ifdef RF_BYPASS_EN
  input  logic                            wr_en_i,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic [DATA_W-1:0]               wr_data_i,
`endif
  output logic [DATA_W-1:0]               data_o,
  output logic                            busy_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef RF_BYPASS_EN
    // A same-cycle write-back both supplies the data and releases the register.
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
      busy_o = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with per-register busy scoreboard.
// Optional macro RF_BYPASS_EN enables write-through forwarding on the read ports.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd0_addr,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd0_data,
  output logic [DATA_W-1:0]   rd1_data,
  output logic                rd0_busy,
  output logic                rd1_busy,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  output logic                claim_ok,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wr_unclaimed
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic                            wr_unclaimed_q, wr_unclaimed_d;

  // Handshake: issue claims with claim_en; the claim is granted (claim_ok) when the
  // register is idle or is being released by a write-back in the same cycle.
  // Write-back (wr_en) is always accepted and releases its register.
  assign claim_ok = claim_en &&
                    (!busy_q[claim_addr] || (wr_en && (wr_addr == claim_addr)));

  always_comb begin
    busy_d         = busy_q;
    wr_unclaimed_d = wr_unclaimed_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
      if (!busy_q[wr_addr]) wr_unclaimed_d = 1'b1;
    end
    // Claim applied after release so a same-address write+claim ends busy.
    if (claim_ok) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q         <= '0;
      busy_q         <= '0;
      wr_unclaimed_q <= 1'b0;
    end else begin
      if (wr_en) regs_q[wr_addr] <= wr_data;
      busy_q         <= busy_d;
      wr_unclaimed_q <= wr_unclaimed_d;
    end
  end

  assign busy_vec     = busy_q;
  assign wr_unclaimed = wr_unclaimed_q;

  rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd0 (
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .addr_i    (rd0_addr),
`ifdef RF_BYPASS_EN
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
`endif
    .data_o    (rd0_data),
    .busy_o    (rd0_busy)
  );

  rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd1 (
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .addr_i    (rd1_addr),
`ifdef RF_BYPASS_EN
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
`endif
    .data_o    (rd1_data),
    .busy_o    (rd1_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default 9x4 instance driven by directed and
// random cycles against an array model, plus a 16x8 instance read back directly.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int DW    = RF_DATA_W;
  localparam int NR    = RF_NUM_REGS;
  localparam int AW    = RF_ADDR_W;
  localparam int EXP_W = 2*DW + 3 + NR + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic          wr_en, claim_en;
  rf_idx_t       wr_addr, rd0_addr, rd1_addr, claim_addr;
  logic [DW-1:0] wr_data, rd0_data, rd1_data;
  logic          rd0_busy, rd1_busy, claim_ok, wr_unclaimed;
  logic [NR-1:0] busy_vec;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .busy_vec(busy_vec), .wr_unclaimed(wr_unclaimed)
  );

  // ---------------- 16x8 instance ----------------
  logic        p_wr_en, p_claim_en, p_rd0_busy, p_rd1_busy, p_claim_ok, p_unclaimed;
  logic [2:0]  p_wr_addr, p_rd0_addr, p_rd1_addr, p_claim_addr;
  logic [15:0] p_wr_data, p_rd0_data, p_rd1_data;
  logic [7:0]  p_busy_vec;

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8)) dut8 (
    .clk(clk), .rst(rst),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rd0_addr(p_rd0_addr), .rd1_addr(p_rd1_addr),
    .rd0_data(p_rd0_data), .rd1_data(p_rd1_data),
    .rd0_busy(p_rd0_busy), .rd1_busy(p_rd1_busy),
    .claim_en(p_claim_en), .claim_addr(p_claim_addr), .claim_ok(p_claim_ok),
    .busy_vec(p_busy_vec), .wr_unclaimed(p_unclaimed)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mdl_regs [NR];
  logic          mdl_busy [NR];
  logic          mdl_unclaimed;
  logic [EXP_W-1:0] exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      mdl_regs[i] = '0;
      mdl_busy[i] = 1'b0;
    end
    mdl_unclaimed = 1'b0;
  endfunction

  // Predict this cycle's visible outputs, then advance the model across the edge.
  function automatic void model_cycle();
    logic [DW-1:0] e_d0, e_d1;
    logic          e_b0, e_b1, e_ok;
    logic [NR-1:0] e_vec;
    e_d0 = mdl_regs[rd0_addr];  e_b0 = mdl_busy[rd0_addr];
    e_d1 = mdl_regs[rd1_addr];  e_b1 = mdl_busy[rd1_addr];
`ifdef RF_BYPASS_EN
    if (wr_en && wr_addr == rd0_addr) begin e_d0 = wr_data; e_b0 = 1'b0; end
    if (wr_en && wr_addr == rd1_addr) begin e_d1 = wr_data; e_b1 = 1'b0; end
`endif
    e_ok = claim_en && (!mdl_busy[claim_addr] || (wr_en && wr_addr == claim_addr));
    for (int i = 0; i < NR; i++) e_vec[i] = mdl_busy[i];
    exp_q.push_back({e_d0, e_d1, e_b0, e_b1, e_ok, e_vec, mdl_unclaimed});
    if (wr_en) begin
      if (!mdl_busy[wr_addr]) mdl_unclaimed = 1'b1;
      mdl_regs[wr_addr] = wr_data;
      mdl_busy[wr_addr] = 1'b0;
    end
    if (e_ok) mdl_busy[claim_addr] = 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic we, input int wa, input int wd, input int r0, input int r1,
                      input logic ce, input int ca);
    @(negedge clk);
    wr_en = we;  wr_addr = rf_idx_t'(wa);  wr_data = DW'(wd);
    rd0_addr = rf_idx_t'(r0);  rd1_addr = rf_idx_t'(r1);
    claim_en = ce;  claim_addr = rf_idx_t'(ca);
    model_cycle();
  endtask

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #4;
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      check("rd0_data",     32'(rd0_data),     32'(e[EXP_W-1 -: DW]));
      check("rd1_data",     32'(rd1_data),     32'(e[EXP_W-DW-1 -: DW]));
      check("rd0_busy",     32'(rd0_busy),     32'(e[NR+3]));
      check("rd1_busy",     32'(rd1_busy),     32'(e[NR+2]));
      check("claim_ok",     32'(claim_ok),     32'(e[NR+1]));
      check("busy_vec",     32'(busy_vec),     32'(e[NR:1]));
      check("wr_unclaimed", 32'(wr_unclaimed), 32'(e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
    claim_en = 0; claim_addr = '0;
    p_wr_en = 0; p_wr_addr = '0; p_wr_data = '0; p_rd0_addr = '0; p_rd1_addr = '0;
    p_claim_en = 0; p_claim_addr = '0;
    model_reset();
    #12 rst = 1'b0;

    // Write reg2 and claim it in the same cycle, then reset asynchronously mid-cycle.
    step(0, 0, 0,     2, 2, 0, 0);
    step(1, 2, 'h1A5, 2, 2, 1, 2);
    step(0, 0, 0,     2, 2, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst rd0_data", 32'(rd0_data), 32'h0);
    check("async_rst busy_vec", 32'(busy_vec), 32'h0);
    check("async_rst wr_unclaimed", 32'(wr_unclaimed), 32'h0);
    model_reset();
    #1 rst = 1'b0;

    // Claim then release reg1.
    step(0, 0, 0,     1, 0, 1, 1);
    step(0, 0, 0,     1, 1, 0, 0);
    step(1, 1, 'h0F3, 1, 1, 0, 0);
    step(0, 0, 0,     1, 1, 0, 0);
    // Refused claim, then write+claim on the same busy register.
    step(0, 0, 0,     3, 3, 1, 3);
    step(0, 0, 0,     3, 3, 1, 3);
    step(1, 3, 'h055, 3, 3, 1, 3);
    step(0, 0, 0,     3, 0, 0, 0);
    // Unclaimed write stays sticky.
    step(1, 0, 'h1FF, 0, 0, 0, 0);
    step(0, 0, 0,     0, 0, 0, 0);
    // Same-cycle read of the register being written.
    step(1, 2, 'h123, 2, 2, 0, 0);
    step(0, 0, 0,     2, 2, 0, 0);
    // Write and claim on different registers, and on the same idle register.
    step(1, 1, 'h0AA, 1, 2, 1, 2);
    step(1, 0, 'h011, 0, 2, 1, 0);
    step(0, 0, 0,     0, 2, 0, 0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 2) == 0), $urandom_range(0, NR-1), $urandom_range(0, (1 << DW) - 1),
           $urandom_range(0, NR-1), $urandom_range(0, NR-1),
           ($urandom_range(0, 1) == 1), $urandom_range(0, NR-1));
    end
    step(0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    // 16x8 instance: write distinct patterns, read back on both ports, claim all.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      p_wr_en = 1'b1; p_wr_addr = 3'(i); p_wr_data = 16'hA5A0 + 16'(i);
    end
    @(negedge clk);
    p_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p_rd0_addr = 3'(i); p_rd1_addr = 3'(7 - i);
      #1;
      check("p8 rd0_data", 32'(p_rd0_data), 32'hA5A0 + 32'(i));
      check("p8 rd1_data", 32'(p_rd1_data), 32'hA5A0 + 32'(7 - i));
    end
    check("p8 wr_unclaimed", 32'(p_unclaimed), 32'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      p_claim_en = 1'b1; p_claim_addr = 3'(i);
      #1;
      check("p8 claim_ok", 32'(p_claim_ok), 32'h1);
    end
    @(negedge clk);
    p_claim_en = 1'b0;
    #1;
    check("p8 busy_vec", 32'(p_busy_vec), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the 4x9-bit two-read/one-write register file, for the pipelined datapath.
- Adds configurable width and depth.
- Adds a per-register scoreboard (busy bits) with a claim/write-back handshake, so issue logic can detect read-after-write hazards.
- Sits between decode/issue (read + claim) and write-back (write + release).

Parameters:
- DATA_W, 9, register data width in bits.
- NUM_REGS, 4, number of registers; must be a power of 2 and >= 2.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all registers and busy bits.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back register index.
- wr_data  in  DATA_W  write-back data.
- rd0_addr  in  ADDR_W  read port 0 index.
- rd1_addr  in  ADDR_W  read port 1 index.
- rd0_data  out  DATA_W  read port 0 data, combinational.
- rd1_data  out  DATA_W  read port 1 data, combinational.
- rd0_busy  out  1  busy bit of rd0_addr (hazard), combinational.
- rd1_busy  out  1  busy bit of rd1_addr, combinational.
- claim_en  in  1  request to mark claim_addr as pending a result.
- claim_addr  in  ADDR_W  register being claimed.
- claim_ok  out  1  combinational; claim_en && !busy[claim_addr] (after same-cycle release, see below).
- busy_vec  out  NUM_REGS  all busy bits, registered.
- wr_unclaimed  out  1  sticky flag: a write hit a register that was not busy; cleared only by rst.

Behaviour:
- Reset, asynchronous: all registers = 0, busy_vec = 0, wr_unclaimed = 0. Outputs settle immediately; no clock needed.
- Reads are combinational from register state. Without bypass, a write is visible on rd*_data the cycle after the edge.
- Write: on posedge with wr_en, reg[wr_addr] <= wr_data. Writes are always accepted, claimed or not.
- Release: a write with wr_en also clears busy[wr_addr].
- Unclaimed write: if busy[wr_addr] was 0, set wr_unclaimed (diagnostic only; the write still happens).
- Claim: on posedge with claim_ok, busy[claim_addr] <= 1. claim_ok is 0 when the register is busy and not being released this cycle; a refused claim changes nothing and the requester retries.
- Same-cycle write and claim, same address, register busy: release happens first, then the claim is granted (claim_ok = 1). End state: busy = 1, data = wr_data.
- Same-cycle write and claim, same address, register not busy: claim granted, busy = 1, wr_unclaimed set.
- Same-cycle write and claim, different addresses: both take effect independently.
- rd0 and rd1 may address the same register; both return identical data/busy.
- Reset asserted mid-operation: takes priority over any same-cycle write or claim; all state is zeroed asynchronously.
- No X propagation: all addresses are in range by construction (power-of-2 depth).

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: if wr_en && wr_addr == rdN_addr, then rdN_data = wr_data and rdN_busy = 0 in the same cycle (write-through forwarding); claim_ok uses the same release forwarding.
- Undefined: rdN_data shows the pre-edge register value and rdN_busy shows the pre-edge busy bit. claim_ok still honours same-cycle release (part of the base handshake).

Decomposition:
- Shared package rf_pkg: default DATA_W/NUM_REGS constants, and a typedef for the register index.
- One natural sub-module, rf_read_port: address mux plus optional bypass, instantiated twice.
- Scoreboard logic stays inline.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing reg2=0x1A5 -> rd0_data reads 0 immediately; busy_vec = 0; wr_unclaimed = 0.
- Claim/release: claim reg1 -> next cycle busy_vec = 4'b0010, rd0_busy = 1 for rd0_addr = 1. Write reg1 = 0x0F3 -> next cycle busy cleared, rd0_data = 0x0F3.
- Refused claim: reg3 busy; claim reg3 without a write -> claim_ok = 0, busy_vec unchanged. Same cycle add wr_en reg3 = 0x055 -> claim_ok = 1, end state busy[3] = 1, reg3 = 0x055.
- Unclaimed write: write reg0 = 0x1FF with busy[0] = 0 -> reg0 = 0x1FF, wr_unclaimed = 1 and stays 1 until rst.
- Bypass: rd0_addr = rd1_addr = 2, write reg2 = 0x123.
  - With RF_BYPASS_EN: both ports show 0x123 that cycle.
  - Without: both ports show the old value, then 0x123 the next cycle.
- Parametrisation: DATA_W = 16, NUM_REGS = 8 -> write and read back all 8 registers with distinct patterns (0xA5A0 + i); claim all 8 -> busy_vec = 8'hFF.
